// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 1 start bit, NrOfDataBits data bits LSB first,
//   optional even parity bit, 1 stop bit. Rx pin is 2-FF synchronized; every bit is
//   sampled mid-cell, floor(D/2) cycles after the detected start edge, D = ClockFrequency/BaudRate.
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   rx_i           serial line, idle high, asynchronous to clk_i
//   data_bits_o    last good word, updated only together with data_valid_o
//   data_valid_o   one-cycle strobe, new word on data_bits_o
//   frame_error_o  one-cycle strobe, stop bit sampled low (then waits for line high)
//   parity_error_o one-cycle strobe, parity mismatch (only with UART_RX_PARITY_EN)
//   busy_o         high while the receiver is not idle
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
  parameter int ClockFrequency = 24_000_000,
  parameter int BaudRate       = 9600,
  parameter int NrOfDataBits   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_i,
  output logic [NrOfDataBits-1:0] data_bits_o,
  output logic                    data_valid_o,
  output logic                    frame_error_o,
`ifdef UART_RX_PARITY_EN
  output logic                    parity_error_o,
`endif
  output logic                    busy_o
);

  localparam int D  = ClockFrequency / BaudRate;
  localparam int H  = D / 2;
  localparam int CW = $clog2(D);
  localparam int IW = $clog2(NrOfDataBits);

  localparam logic [CW-1:0] CntFull = CW'(D - 1);
  localparam logic [CW-1:0] CntHalf = CW'(H - 1);
  localparam logic [IW-1:0] IdxLast = IW'(NrOfDataBits - 1);

  if (D < 4) begin : g_bad_divisor
    $error("uart_rx: ClockFrequency/BaudRate must be at least 4");
  end
  if (NrOfDataBits < 5 || NrOfDataBits > 9) begin : g_bad_width
    $error("uart_rx: NrOfDataBits must be in 5..9");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_e;

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  logic [1:0]              sync_q;
  logic                    rxs;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NrOfDataBits-1:0] shift_q, shift_d;
  // Stop-sample results are held one cycle so the strobes appear on the edge after the sample.
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_ferr_q, pend_ferr_d;
  logic                    valid_q, ferr_q, busy_q;
  logic [NrOfDataBits-1:0] data_q;
`ifdef UART_RX_PARITY_EN
  logic                    par_bad_q, par_bad_d;
  logic                    pend_perr_q, pend_perr_d;
  logic                    perr_q;
`endif

  assign rxs = sync_q[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    pend_valid_d = 1'b0;
    pend_ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    pend_perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in; a short low pulse is treated as noise.
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[NrOfDataBits-1:1]};
          if (idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CntFull) begin
          cnt_d     = '0;
          par_bad_d = rxs ^ (^shift_q);
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          // A low stop bit wins over a parity mismatch.
          if (!rxs) begin
            pend_ferr_d = 1'b1;
            state_d     = S_BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            pend_perr_d = 1'b1;
            state_d     = S_IDLE;
`endif
          end else begin
            pend_valid_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it produces a single frame error.
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_ferr_q  <= 1'b0;
      valid_q      <= 1'b0;
      ferr_q       <= 1'b0;
      busy_q       <= 1'b0;
      data_q       <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      pend_perr_q  <= 1'b0;
      perr_q       <= 1'b0;
`endif
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      pend_valid_q <= pend_valid_d;
      pend_ferr_q  <= pend_ferr_d;
      valid_q      <= pend_valid_q;
      ferr_q       <= pend_ferr_q;
      // Registered from the current state: drops on the same edge the strobe rises.
      busy_q       <= (state_q != S_IDLE);
      if (pend_valid_q) data_q <= shift_q;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      pend_perr_q  <= pend_perr_d;
      perr_q       <= pend_perr_q;
`endif
    end
  end

  assign data_bits_o   = data_q;
  assign data_valid_o  = valid_q;
  assign frame_error_o = ferr_q;
  assign busy_o        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error_o = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with D=16, 8 data bits.
// Stimulus pushes the expected strobe (kind, word, cycle) per frame; a monitor pops on every strobe.
module tb_uart_rx;
  localparam int CF = 16;
  localparam int BR = 1;
  localparam int N  = 8;
  localparam int D  = CF / BR;
  localparam int H  = D / 2;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int STOP_IDX = 1 + N + P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [N-1:0] data;
  logic         dv, fe, pe, busy;

  uart_rx #(.ClockFrequency(CF), .BaudRate(BR), .NrOfDataBits(N)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rx_i          (rx),
    .data_bits_o   (data),
    .data_valid_o  (dv),
    .frame_error_o (fe),
`ifdef UART_RX_PARITY_EN
    .parity_error_o(pe),
`endif
    .busy_o        (busy)
  );
`ifndef UART_RX_PARITY_EN
  assign pe = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;   // {parity_error, frame_error, data_valid}
    logic [7:0] data;
    int         when;
  } exp_t;

  exp_t       sbq[$];
  int         vcyc[$];
  logic [7:0] model_last = 8'h00;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      model_last = 8'h00;
    end else if (dv || fe || pe) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got dv=%0b fe=%0b pe=%0b expected none (cycle %0d)",
                 dv, fe, pe, cyc);
      end else begin
        e = sbq.pop_front();
        chk("strobe_kind", {29'd0, pe, fe, dv}, {29'd0, e.kind});
        chk("strobe_cycle", cyc, e.when);
        if (e.kind == 3'b001) begin
          chk("data_bits", {24'd0, data}, {24'd0, e.data});
          chk("busy_with_valid", {31'd0, busy}, 32'd0);
          model_last = e.data;
          vcyc.push_back(cyc);
        end else begin
          chk("data_bits_held", {24'd0, data}, {24'd0, model_last});
        end
      end
    end
  end

  // Drives one frame starting at the current negedge. A bad stop bit holds the line
  // low for 5*D cycles, then returns it high for 2*D.
  task automatic send(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int stop_len);
    logic bits[$];
    exp_t e;
    int   t0;
    bits.push_back(1'b0);
    for (int i = 0; i < N; i++) bits.push_back(d[i]);
    if (P == 1) bits.push_back((^d) ^ !par_ok);
    t0 = cyc + 1;  // first rising edge that sees the start bit
    e.data = d;
    e.when = t0 + 2 + H + STOP_IDX * D + 1;
    if (!stop_ok)                e.kind = 3'b010;
    else if (P == 1 && !par_ok)  e.kind = 3'b100;
    else                         e.kind = 3'b001;
    sbq.push_back(e);
    foreach (bits[i]) begin
      rx = bits[i];
      repeat (D) @(negedge clk);
    end
    rx = stop_ok;
    if (stop_ok) begin
      repeat (stop_len) @(negedge clk);
    end else begin
      repeat (5 * D) @(negedge clk);
      rx = 1'b1;
      repeat (2 * D) @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] rd;
    bit         s_ok, p_ok;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", {31'd0, dv}, 32'd0);
    chk("reset_ferr", {31'd0, fe}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("reset_perr", {31'd0, pe}, 32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short low pulse: busy rises, then a false start with no strobe.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("false_start_busy", {31'd0, busy}, 32'd1);
    repeat (2 * D) @(negedge clk);
    chk("false_start_idle", {31'd0, busy}, 32'd0);
    chk("false_start_data", {24'd0, data}, 32'd0);

    // First good frame, with busy rise timing.
    fork
      send(8'hA5, 1'b1, 1'b1, 2 * D);
      begin
        repeat (3) @(negedge clk);
        chk("busy_before_rise", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("busy_rise", {31'd0, busy}, 32'd1);
      end
    join
    chk("busy_after_frame", {31'd0, busy}, 32'd0);

    // Low stop bit with line held low, then recovery.
    send(8'h3C, 1'b0, 1'b1, 0);
    send(8'h11, 1'b1, 1'b1, 2 * D);

    // Reset in the middle of data bit 3.
    pat = 8'hC3;
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = pat[i];
      repeat (D) @(negedge clk);
    end
    rx = pat[3];
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_data", {24'd0, data}, 32'd0);
    chk("midreset_valid", {31'd0, dv}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (2 * D) @(negedge clk);
    chk("after_reset_data", {24'd0, data}, 32'd0);
    send(8'h5A, 1'b1, 1'b1, 2 * D);

    // Back-to-back frames with minimum-length stop bit.
    send(8'h00, 1'b1, 1'b1, D);
    send(8'hFF, 1'b1, 1'b1, 2 * D);
    if (vcyc.size() >= 2) begin
      chk("b2b_spacing", vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2], (STOP_IDX + 1) * D);
    end else begin
      total++;
      bad++;
      $display("FAIL b2b_spacing: got %0d valid strobes expected at least 2", vcyc.size());
    end

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 2 * D);
    send(8'h07, 1'b1, 1'b0, 2 * D);
`endif

    // Randomized frames: random words, occasional bad stop / parity, random stop length.
    for (int n = 0; n < 40; n++) begin
      rd   = 8'($urandom);
      s_ok = ($urandom_range(0, 5) != 0);
      p_ok = (P == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      send(rd, s_ok, p_ok, D + $urandom_range(0, D));
    end

    for (int i = 0; i < 4 * D && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
